// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cacheline adaptor between an icache and a dcache.
// A request seen in IDLE is latched (op, address, write line) and presented
// to the adaptor from those latched copies until pmem_resp, so the requesters
// may change or drop their inputs mid-transaction.
// Optional build macro ARB_RR_EN: simultaneous requests alternate between the
// caches via a last_grant register. Without it the dcache always wins a tie.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate among live requests
// GRANT_I | icache line read outstanding at the adaptor
// GRANT_D | dcache line read or writeback outstanding at the adaptor
module mem_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              d_req;
   logic              pick_d;
`ifdef ARB_RR_EN
   // 1 when the most recent grant went to the dcache
   logic              last_grant_q, last_grant_d;
`endif

   assign d_req = d_read | d_write;

   // Arbitration winner: dcache on a tie unless round-robin says it went last
`ifdef ARB_RR_EN
   assign pick_d = d_req & (~i_read | ~last_grant_q);
`else
   assign pick_d = d_req;
`endif

   // Next-state and latch-capture logic
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d = GRANT_D;
               // a simultaneous read+write request is served as the writeback
               wr_d    = d_write;
               rd_d    = ~d_write;
               addr_d  = d_addr;
               wdata_d = d_wdata;
`ifdef ARB_RR_EN
               last_grant_d = 1'b1;
`endif
            end else if (i_read) begin
               state_d = GRANT_I;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
               addr_d  = i_addr;
               wdata_d = '0;
`ifdef ARB_RR_EN
               last_grant_d = 1'b0;
`endif
            end
         end
         GRANT_I, GRANT_D: begin
            if (pmem_resp) begin
               state_d = IDLE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
   end

   // State and latched transaction registers; reset drops any outstanding request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef ARB_RR_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign pmem_read  = rd_q;
   assign pmem_write = wr_q;
   assign pmem_addr  = addr_q;
   assign pmem_wdata = wdata_q;

   assign i_resp  = (state_q == GRANT_I) & pmem_resp;
   assign d_resp  = (state_q == GRANT_D) & pmem_resp;
   assign i_rdata = i_resp ? pmem_rdata : '0;
   assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_W, default 256: cacheline width in bits for all data buses.
REQ-002 Parameter ADDR_W, default 32: address width for all address buses.
REQ-003 The block SHALL have the following ports, one per line, clock and reset first:
clk  in  1  sole clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset.
i_read  in  1  icache line-read request.
i_addr  in  ADDR_W  icache line address.
i_rdata  out  LINE_W  line returned to icache.
i_resp  out  1  icache transaction complete.
d_read  in  1  dcache line-read request.
d_write  in  1  dcache line-write request.
d_addr  in  ADDR_W  dcache line address.
d_wdata  in  LINE_W  dcache writeback line.
d_rdata  out  LINE_W  line returned to dcache.
d_resp  out  1  dcache transaction complete.
pmem_read  out  1  read to cacheline adaptor.
pmem_write  out  1  write to cacheline adaptor.
pmem_addr  out  ADDR_W  line address to adaptor.
pmem_wdata  out  LINE_W  write line to adaptor.
pmem_rdata  in  LINE_W  line from adaptor.
pmem_resp  in  1  adaptor transaction complete.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, GRANT_I, GRANT_D.
REQ-005 In IDLE, pmem_read, pmem_write, i_resp and d_resp SHALL be 0.
REQ-006 In IDLE with no request asserted, the FSM SHALL stay in IDLE.
REQ-007 In IDLE, the arbiter SHALL choose a winner among asserted requests per REQ-015, latch the winner's op, address and wdata, and enter that winner's GRANT state on the next edge.
REQ-008 In GRANT_x, pmem_read, pmem_write, pmem_addr and pmem_wdata SHALL be driven only from the latched values, never from live requester inputs.
REQ-009 When d_read and d_write are both 1 at grant, the latched op SHALL be write.
REQ-010 In GRANT_x with pmem_resp=1, x_resp SHALL be 1 in that same cycle and x_rdata SHALL equal pmem_rdata; the FSM SHALL return to IDLE on the next edge.
REQ-011 The non-granted requester's resp SHALL be 0 at all times, and its rdata SHALL be 0.
REQ-012 A requester deasserting mid-grant SHALL NOT abort the transaction; the pmem request holds until pmem_resp.
REQ-013 Latency: a request seen in IDLE at cycle N SHALL produce a pmem request at cycle N+1; after resp at cycle M, the next grant SHALL be no earlier than cycle M+2, with IDLE at M+1.
REQ-014 A request still asserted in the IDLE cycle after its own resp SHALL be treated as a new request.
REQ-015 Without the macro of REQ-019, simultaneous requests SHALL be granted to the dcache.

Reset
REQ-016 On rst=0 the FSM SHALL enter IDLE asynchronously, and pmem_read, pmem_write, i_resp and d_resp SHALL be 0 immediately.
REQ-017 The latched op, address and wdata SHALL reset to 0; when REQ-019 is compiled in, last_grant SHALL reset to I.
REQ-018 Reset during a grant SHALL abandon the outstanding pmem transaction with no resp to either requester.

Configuration
REQ-019 With ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin using a last_grant register updated at each grant; without it, dcache fixed priority per REQ-015 applies and no last_grant register exists.

Verification
REQ-020 i_read=1, addr=0x60 at cycle 0, pmem_resp at cycle 5 -> pmem_read=1 and pmem_addr=0x60 in cycles 1-5, i_resp=1 at cycle 5 only, IDLE at cycle 6.
REQ-021 d_write=1 with d_wdata=0xA5.. and i_read=1 simultaneously, macro off -> GRANT_D with pmem_write=1; icache granted at the first IDLE after d_resp.
REQ-022 Macro on, both requesters asserting continuously -> grants alternate D,I,D,I starting with D after reset.
REQ-023 rst=0 asserted mid GRANT_I -> pmem_read=0 the same cycle with no i_resp; after release, the FSM is IDLE.
REQ-024 d_read and d_write both 1 -> pmem_write=1 and pmem_read=0; i_addr changing during GRANT_D -> pmem_addr unchanged.
